read_stage_p: RTL and testbench

- Parametrised successor to the operand-read stage of the RISC-V pipeline; sits between fetch and execute.
- Holds the architectural register file and takes one write-back port.
- Decodes the instruction format, reads rs1/rs2 and builds the sign-extended immediate.
- Passes IR, PC, operands and immediate downstream through one output register under a valid/ready handshake with stall.
- Generalised from 32x32 to XLEN and NREGS (RV32E/RV64); adds illegal-instruction flagging and optional write-back bypass.

---
 rtl/read_pkg.sv | 34 +++
 rtl/read_stage_p_imm_gen.sv | 61 ++++++
 rtl/read_stage_p.sv | 200 ++++++++++++++++++++
 tb/tb_read_stage_p.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_pkg.sv
// -----------------------------------------------------------------------------
// read_pkg
// Shared definitions for the operand-read stage and its immediate generator:
// RV base opcodes, the instruction-format enum and the default datapath
// parameters. Imported by imm_gen and read_stage_p.
// -----------------------------------------------------------------------------
package read_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_e;

endpackage

// File: rtl/read_stage_p_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational instruction-format decode and immediate builder. The
// immediate is formed at 32 bits and sign-extended from IR[31] to XLEN.
// Unknown opcodes report FMT_NONE with a zero immediate.
//
// Ports:
//   ir_i   in  32    instruction word
//   fmt_o  out fmt_e decoded format (FMT_NONE for unsupported opcodes)
//   imm_o  out XLEN  sign-extended immediate (0 for R-type and FMT_NONE)
// -----------------------------------------------------------------------------
module imm_gen
    import read_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     ir_i,
    output fmt_e            fmt_o,
    output logic [XLEN-1:0] imm_o
);

    logic signed [31:0] imm32;

    always_comb begin
        fmt_o = FMT_NONE;
        imm32 = '0;
        case (ir_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {ir_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            // Shift-immediates keep shamt/funct7 in the immediate; execute masks them.
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: begin
                fmt_o = FMT_I;
                imm32 = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{20{ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            end
            OPC_OP: begin
                fmt_o = FMT_R;
            end
            default: begin
                fmt_o = FMT_NONE;
            end
        endcase
    end

    // XLEN >= 32, so at least one copy of the sign bit is always replicated.
    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/read_stage_p.sv
// -----------------------------------------------------------------------------
// read_stage_p
// Operand-read stage between fetch and execute. Holds the architectural
// register file (one write-back port), decodes the format, reads rs1/rs2,
// builds the immediate and registers everything into a single output slot
// under a valid/ready handshake with a global stall.
//
// Optional feature (macro READ_BYPASS_EN):
//   defined   - a write-back on the accepting edge is forwarded into the
//               captured operands, and a held output slot has its operands
//               refreshed by write-backs to its rs1/rs2 (not for U/J or
//               illegal instructions).
//   undefined - same-edge reads see the old value; held outputs never change.
//
// Ports:
//   clk, rst_n               clock (rising), asynchronous active-low reset
//   IR, PC, v_in / r_out     upstream instruction, address, handshake
//   WB_data, WB_address,v_wb write-back port
//   IR_out, PC_out           registered instruction and address
//   A_out, B_out, I_out      rs1 operand, rs2 operand, immediate
//   ILL_out                  illegal opcode or register index >= NREGS
//   v_out / r_in, stall      downstream handshake, global freeze
// -----------------------------------------------------------------------------
module read_stage_p
    import read_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     IR,
    input  logic [XLEN-1:0] PC,
    input  logic            v_in,
    output logic            r_out,
    input  logic [XLEN-1:0] WB_data,
    input  logic [4:0]      WB_address,
    input  logic            v_wb,
    output logic [31:0]     IR_out,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] A_out,
    output logic [XLEN-1:0] B_out,
    output logic [XLEN-1:0] I_out,
    output logic            ILL_out,
    output logic            v_out,
    input  logic            r_in,
    input  logic            stall
);

    localparam int RW = $clog2(NREGS);

    logic [XLEN-1:0] rf_q [NREGS];

    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1, rs2;
    logic            use_a, use_b, bad_a, bad_b, ill;
    logic            wb_en, accept;
    logic [XLEN-1:0] rd_a, rd_b;

    logic            vld_q, vld_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            ill_q, ill_d;
`ifdef READ_BYPASS_EN
    logic            use_a_q, use_a_d;
    logic            use_b_q, use_b_d;
`endif

    function automatic logic in_range(input logic [4:0] idx);
        return int'(idx) < NREGS;
    endfunction

    // x0 and indices beyond the implemented file read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || !in_range(idx))
            return '0;
        return rf_q[idx[RW-1:0]];
    endfunction

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ir_i  (IR),
        .fmt_o (fmt),
        .imm_o (imm)
    );

    // ---- decode / operand read (combinational, ahead of the output slot) ----
    assign rs1    = IR[19:15];
    assign rs2    = IR[24:20];
    assign use_a  = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign use_b  = fmt inside {FMT_R, FMT_S, FMT_B};
    assign bad_a  = use_a && !in_range(rs1);
    assign bad_b  = use_b && !in_range(rs2);
    assign ill    = (fmt == FMT_NONE) || bad_a || bad_b;
    assign wb_en  = v_wb && (WB_address != 5'd0) && in_range(WB_address);

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (use_a)
            rd_a = rf_read(rs1);
        if (use_b)
            rd_b = rf_read(rs2);
`ifdef READ_BYPASS_EN
        // wb_en already excludes out-of-range indices, so a bad index never forwards.
        if (use_a && wb_en && WB_address == rs1)
            rd_a = WB_data;
        if (use_b && wb_en && WB_address == rs2)
            rd_b = WB_data;
`endif
    end

    assign r_out  = !stall && (!vld_q || r_in);
    assign accept = v_in && r_out;

    always_comb begin
        vld_d = vld_q;
        ir_d  = ir_q;
        pc_d  = pc_q;
        a_d   = a_q;
        b_d   = b_q;
        imm_d = imm_q;
        ill_d = ill_q;
`ifdef READ_BYPASS_EN
        use_a_d = use_a_q;
        use_b_d = use_b_q;
`endif
        if (accept) begin
            vld_d = 1'b1;
            ir_d  = IR;
            pc_d  = PC;
            a_d   = (fmt == FMT_NONE) ? '0 : rd_a;
            b_d   = (fmt == FMT_NONE) ? '0 : rd_b;
            imm_d = imm;
            ill_d = ill;
`ifdef READ_BYPASS_EN
            use_a_d = use_a;
            use_b_d = use_b;
`endif
        end else if (r_in && !stall) begin
            vld_d = 1'b0;
        end
`ifdef READ_BYPASS_EN
        // Reaching here with vld_q set means the slot is being held.
        else if (vld_q && !ill_q && wb_en) begin
            if (use_a_q && WB_address == ir_q[19:15])
                a_d = WB_data;
            if (use_b_q && WB_address == ir_q[24:20])
                b_d = WB_data;
        end
`endif
    end

    // ---- output slot register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ir_q  <= '0;
            pc_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            ill_q <= 1'b0;
`ifdef READ_BYPASS_EN
            use_a_q <= 1'b0;
            use_b_q <= 1'b0;
`endif
        end else begin
            vld_q <= vld_d;
            ir_q  <= ir_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            imm_q <= imm_d;
            ill_q <= ill_d;
`ifdef READ_BYPASS_EN
            use_a_q <= use_a_d;
            use_b_q <= use_b_d;
`endif
        end
    end

    // Register file is not reset; a write on an edge seen during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wb_en)
            rf_q[WB_address[RW-1:0]] <= WB_data;
    end

    assign v_out   = vld_q;
    assign IR_out  = ir_q;
    assign PC_out  = pc_q;
    assign A_out   = a_q;
    assign B_out   = b_q;
    assign I_out   = imm_q;
    assign ILL_out = ill_q;

endmodule

// File: tb/tb_read_stage_p.sv
module tb_read_stage_p;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
`ifdef READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IR = '0;
    logic [63:0] PC = '0;
    logic        v_in = 1'b0, r_in = 1'b0, stall = 1'b0, v_wb = 1'b0;
    logic [4:0]  WB_address = '0;
    logic [63:0] WB_data = '0;

    logic        r_out, ILL_out, v_out;
    logic [31:0] IR_out;
    logic [63:0] PC_out, A_out, B_out, I_out;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    read_stage_p #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .PC(PC), .v_in(v_in), .r_out(r_out),
        .WB_data(WB_data), .WB_address(WB_address), .v_wb(v_wb),
        .IR_out(IR_out), .PC_out(PC_out), .A_out(A_out), .B_out(B_out),
        .I_out(I_out), .ILL_out(ILL_out), .v_out(v_out), .r_in(r_in), .stall(stall)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Immediate value is computed arithmetically from field weights.
    function automatic void mdec(input logic [31:0] ir, output bit ua, output bit ub,
                                 output bit bad, output longint imm);
        longint neg12 = ir[31] ? 64'sd4096 : 64'sd0;
        ua = 1'b0; ub = 1'b0; bad = 1'b0; imm = 0;
        case (ir[6:0])
            7'b0110111, 7'b0010111:
                imm = longint'(ir[31:12]) * 4096 - (ir[31] ? (longint'(1) <<< 32) : 0);
            7'b1101111:
                imm = longint'(ir[19:12]) * 4096 + longint'(ir[20]) * 2048
                      + longint'(ir[30:21]) * 2 - (ir[31] ? (longint'(1) <<< 20) : 0);
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                ua = 1'b1;
                imm = longint'(ir[31:20]) - neg12;
            end
            7'b1100011: begin
                ua = 1'b1; ub = 1'b1;
                imm = longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32
                      + longint'(ir[11:8]) * 2 - neg12;
            end
            7'b0100011: begin
                ua = 1'b1; ub = 1'b1;
                imm = longint'(ir[31:25]) * 32 + longint'(ir[11:7]) - neg12;
            end
            7'b0110011: begin
                ua = 1'b1; ub = 1'b1;
            end
            default: bad = 1'b1;
        endcase
    endfunction

    logic [63:0] m_rf [32];
    bit          m_v = 1'b0, m_ill = 1'b0;
    logic [31:0] m_ir = '0;
    logic [63:0] m_pc = '0, m_a = '0, m_b = '0, m_i = '0;

    bit          mu_a, mu_b, mbad, hu_a, hu_b, hbad, m_rdy, m_acc, m_wen, n_ill;
    longint      mimm, himm;
    logic [63:0] n_a, n_b;

    initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v = 1'b0; m_ill = 1'b0; m_ir = '0; m_pc = '0; m_a = '0; m_b = '0; m_i = '0;
        end else begin
            m_rdy = !stall && (!m_v || r_in);
            m_acc = v_in && m_rdy;
            m_wen = v_wb && WB_address != 0 && int'(WB_address) < NREGS;
            mdec(IR, mu_a, mu_b, mbad, mimm);
            n_a = '0; n_b = '0; n_ill = mbad;
            if (mbad) mimm = 0;
            if (mu_a) begin
                if (int'(IR[19:15]) >= NREGS) n_ill = 1'b1;
                else if (BYP && m_wen && WB_address == IR[19:15]) n_a = WB_data;
                else n_a = m_rf[IR[19:15]];
            end
            if (mu_b) begin
                if (int'(IR[24:20]) >= NREGS) n_ill = 1'b1;
                else if (BYP && m_wen && WB_address == IR[24:20]) n_b = WB_data;
                else n_b = m_rf[IR[24:20]];
            end
            if (m_acc) begin
                m_v = 1'b1; m_ir = IR; m_pc = PC; m_a = n_a; m_b = n_b;
                m_i = 64'(mimm); m_ill = n_ill;
            end else if (r_in && !stall) begin
                m_v = 1'b0;
            end else if (BYP && m_v && m_wen && !m_ill) begin
                mdec(m_ir, hu_a, hu_b, hbad, himm);
                if (hu_a && WB_address == m_ir[19:15]) m_a = WB_data;
                if (hu_b && WB_address == m_ir[24:20]) m_b = WB_data;
            end
            if (m_wen) m_rf[WB_address] = WB_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("v_out", v_out, m_v);
            chk1("r_out", r_out, !stall && (!m_v || r_in));
            chk64("IR_out", 64'(IR_out), 64'(m_ir));
            chk64("PC_out", PC_out, m_pc);
            chk64("A_out", A_out, m_a);
            chk64("B_out", B_out, m_b);
            chk64("I_out", I_out, m_i);
            chk1("ILL_out", ILL_out, m_ill);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic cyc(input bit vi, input logic [31:0] ir, input bit ri, input bit st,
                       input bit vw, input logic [4:0] wa, input logic [63:0] wd);
        v_in = vi; IR = ir; PC = {32'h0000_1000, ir ^ 32'h5A5A_0000};
        r_in = ri; stall = st; v_wb = vw; WB_address = wa; WB_data = wd;
        @(posedge clk); #1;
    endtask

    logic [31:0] ia, ib;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        chk1("reset v_out", v_out, 1'b0);
        chk64("reset A_out", A_out, 64'h0);
        rst_n = 1'b1;

        // register file fill: reg[r] = r, x0 gets 0xDEAD (must be dropped)
        for (int r = 0; r < 32; r++)
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'(r), (r == 0) ? 64'hDEAD : 64'(r));

        cyc(1'b1, add_i(5'd1, 5'd4, 5'd5), 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("add A", A_out, 64'd4);
        chk64("add B", B_out, 64'd5);
        chk1("add v", v_out, 1'b1);

        cyc(1'b1, {20'h80000, 5'd2, 7'b0110111}, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("lui imm", I_out, 64'hFFFF_FFFF_8000_0000);
        chk64("lui A", A_out, 64'h0);

        cyc(1'b1, {20'hFFFFF, 5'd1, 7'b1101111}, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("jal imm", I_out, 64'hFFFF_FFFF_FFFF_FFFE);

        cyc(1'b1, {1'b1, 6'b0, 5'd2, 5'd1, 3'b110, 4'b0, 1'b0, 7'b1100011}, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("bltu imm", I_out, 64'hFFFF_FFFF_FFFF_F000);
        chk64("bltu B", B_out, 64'd2);

        cyc(1'b1, {7'b0100000, 5'd5, 5'd2, 3'b101, 5'd1, 7'b0010011}, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("srai imm", I_out, 64'h405);

        cyc(1'b1, {7'b1111111, 5'd5, 5'd6, 3'b010, 5'b11000, 7'b0100011}, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("sw imm", I_out, 64'hFFFF_FFFF_FFFF_FFF8);

        cyc(1'b1, add_i(5'd1, 5'd17, 5'd5), 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk1("rs1 17 ill", ILL_out, 1'b1);
        chk64("rs1 17 A", A_out, 64'h0);

        cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk1("opc7f ill", ILL_out, 1'b1);
        chk64("opc7f imm", I_out, 64'h0);
        chk1("opc7f v", v_out, 1'b1);

        cyc(1'b1, add_i(5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("x0 read", A_out, 64'h0);
        chk1("x0 ill", ILL_out, 1'b0);

        // back-pressure: r_in low for 3 cycles while the next instruction waits
        ia = add_i(5'd1, 5'd6, 5'd7);
        ib = add_i(5'd2, 5'd8, 5'd9);
        cyc(1'b1, ia, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, ib, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
            chk64("bp hold IR", 64'(IR_out), 64'(ia));
            chk1("bp r_out", r_out, 1'b0);
        end
        cyc(1'b1, ib, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("bp next IR", 64'(IR_out), 64'(ib));
        chk64("bp next A", A_out, 64'd8);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk1("bp drain v", v_out, 1'b0);

        // stall with r_in high holds the slot
        ia = add_i(5'd1, 5'd10, 5'd11);
        cyc(1'b1, ia, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        cyc(1'b1, add_i(5'd1, 5'd12, 5'd13), 1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        cyc(1'b1, add_i(5'd1, 5'd12, 5'd13), 1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        chk64("stall hold IR", 64'(IR_out), 64'(ia));
        chk1("stall r_out", r_out, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);

        // same-edge write-back and accept of ADD x3,x3
        cyc(1'b1, add_i(5'd1, 5'd3, 5'd3), 1'b1, 1'b0, 1'b1, 5'd3, 64'h55);
        chk64("same-edge A", A_out, BYP ? 64'h55 : 64'd3);
        chk64("same-edge B", B_out, BYP ? 64'h55 : 64'd3);

        // held slot reading x7 while x7 is written
        cyc(1'b1, add_i(5'd1, 5'd7, 5'd8), 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 64'h99);
        chk64("held A", A_out, BYP ? 64'h99 : 64'd7);
        chk64("held B", B_out, 64'd8);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);

        // asynchronous reset mid-handshake; write-back during reset is lost
        cyc(1'b1, add_i(5'd1, 5'd9, 5'd9), 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        v_in = 1'b1; IR = add_i(5'd1, 5'd2, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async rst v", v_out, 1'b0);
        chk64("async rst IR", 64'(IR_out), 64'h0);
        chk64("async rst A", A_out, 64'h0);
        v_in = 1'b0; v_wb = 1'b1; WB_address = 5'd9; WB_data = 64'h1234;
        @(posedge clk); #1;
        v_wb = 1'b0;
        rst_n = 1'b1;
        cyc(1'b1, add_i(5'd1, 5'd9, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        chk64("lost wb A", A_out, 64'd9);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
